// File: rtl/cas_pkg.sv
// Shared cassette timing constants and framer state encoding for the Oric
// tape generator/decoder pair.
package cas_pkg;

  localparam int CAS_T1_LOW     = 4354;
  localparam int CAS_T1_PERIOD  = 8708;
  localparam int CAS_T0_LOW     = 6530;
  localparam int CAS_T0_PERIOD  = 15239;
  localparam int CAS_BIT_THRESH = 6531;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } cas_state_e;

endpackage

// File: rtl/cas_pulse_classifier.sv
// Synchronises the tape level, measures each high pulse and turns it into a
// 1/0 bit decision; also tracks edge activity for carrier detection.
module cas_pulse_classifier
  import cas_pkg::*;
#(
  parameter int BIT_THRESH = CAS_BIT_THRESH,
  parameter int MIN_HIGH   = 1000,
  parameter int TIMEOUT    = 20000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_tape,
  output logic o_bit_valid,
  output logic o_bit_val,
  output logic o_carrier,
  output logic o_timeout
);

  localparam logic [14:0] THR_W = 15'(BIT_THRESH);
  localparam logic [14:0] MIN_W = 15'(MIN_HIGH);
  localparam logic [14:0] TO_W  = 15'(TIMEOUT);

  logic        r_s1, r_s2, r_s3;
  logic [14:0] r_width, r_idle;
  logic        w_rise, w_fall, w_clr;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_clr  = ~reset_n | ~i_enable;

  // Synchroniser keeps running while disabled so edges are clean on re-enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_tape;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_width     <= '0;
      o_bit_valid <= 1'b0;
      o_bit_val   <= 1'b0;
    end else begin
      if (w_rise)
        r_width <= '0;
      else if (r_s2 && r_width != 15'h7FFF)
        r_width <= r_width + 15'd1;
      o_bit_valid <= w_fall && (r_width >= MIN_W);
      o_bit_val   <= (r_width < THR_W);
    end
  end

  // Idle counter parks at TIMEOUT so the timeout pulse fires once per loss.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_idle    <= '0;
      o_carrier <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (w_rise || w_fall) begin
        r_idle    <= '0;
        o_carrier <= 1'b1;
      end else if (r_idle != TO_W) begin
        r_idle <= r_idle + 15'd1;
        if (r_idle == TO_W - 15'd1) begin
          o_carrier <= 1'b0;
          o_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cas_sig_dec.sv
// Cassette signal decoder: frames classified tape bits into start/8 data/
// parity/stop bytes and reports leader-gap and carrier status.
module cas_sig_dec
  import cas_pkg::*;
#(
  parameter int BIT_THRESH = CAS_BIT_THRESH,
  parameter int MIN_HIGH   = 1000,
  parameter int TIMEOUT    = 20000,
  parameter int GAP_BITS   = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       tape_in,
  output logic [7:0] dout,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       in_gap,
  output logic       carrier
);

  localparam logic [7:0] GAP_TH = 8'(GAP_BITS);

  logic       w_bit_valid, w_bit_val, w_timeout;
  cas_state_e r_state, w_state_n;
  logic [7:0] r_sh, w_sh_n, r_gap, w_gap_n, r_dout, w_dout_n;
  logic [2:0] r_idx, w_idx_n;
  logic       r_acc, w_acc_n, r_perr, w_perr_n, r_in_gap, w_in_gap_n;
  logic       r_parity_err, w_parity_err_n, r_frame_err, w_frame_err_n;
  logic       r_dv, w_dv_n;

  cas_pulse_classifier #(
    .BIT_THRESH (BIT_THRESH),
    .MIN_HIGH   (MIN_HIGH),
    .TIMEOUT    (TIMEOUT)
  ) u_cls (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_enable    (enable),
    .i_tape      (tape_in),
    .o_bit_valid (w_bit_valid),
    .o_bit_val   (w_bit_val),
    .o_carrier   (carrier),
    .o_timeout   (w_timeout)
  );

  always_comb begin
    w_state_n      = r_state;
    w_sh_n         = r_sh;
    w_acc_n        = r_acc;
    w_idx_n        = r_idx;
    w_perr_n       = r_perr;
    w_gap_n        = r_gap;
    w_in_gap_n     = r_in_gap;
    w_dout_n       = r_dout;
    w_parity_err_n = r_parity_err;
    w_frame_err_n  = r_frame_err;
    w_dv_n         = 1'b0;
    if (w_timeout) begin
      w_state_n  = HUNT;
      w_gap_n    = '0;
      w_in_gap_n = 1'b0;
    end else if (w_bit_valid) begin
      case (r_state)
        HUNT: begin
          if (w_bit_val) begin
            w_gap_n    = (r_gap == 8'hFF) ? r_gap : r_gap + 8'd1;
            w_in_gap_n = (w_gap_n >= GAP_TH);
          end else begin
            w_sh_n     = '0;
            w_acc_n    = 1'b1;
            w_idx_n    = '0;
            w_gap_n    = '0;
            w_in_gap_n = 1'b0;
            w_state_n  = DATA;
          end
        end
        DATA: begin
          w_sh_n  = {w_bit_val, r_sh[7:1]};
          w_acc_n = r_acc ^ w_bit_val;
          w_idx_n = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_n = PARITY;
        end
        PARITY: begin
          // Accumulator started at 1, so it now holds the expected (odd) parity.
          w_perr_n  = (w_bit_val != r_acc);
          w_state_n = STOP;
        end
        STOP: begin
          w_dout_n       = r_sh;
          w_parity_err_n = r_perr;
          w_frame_err_n  = ~w_bit_val;
          w_dv_n         = 1'b1;
          w_state_n      = HUNT;
        end
        default: w_state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      r_state      <= HUNT;
      r_sh         <= '0;
      r_acc        <= 1'b0;
      r_idx        <= '0;
      r_perr       <= 1'b0;
      r_gap        <= '0;
      r_in_gap     <= 1'b0;
      r_dout       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_dv         <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_sh         <= w_sh_n;
      r_acc        <= w_acc_n;
      r_idx        <= w_idx_n;
      r_perr       <= w_perr_n;
      r_gap        <= w_gap_n;
      r_in_gap     <= w_in_gap_n;
      r_dout       <= w_dout_n;
      r_parity_err <= w_parity_err_n;
      r_frame_err  <= w_frame_err_n;
      r_dv         <= w_dv_n;
    end
  end

  assign dout       = r_dout;
  assign data_valid = r_dv;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign in_gap     = r_in_gap;

endmodule
